// File: rtl/ex_arith_hilo_pkg.sv
// Shared widths, MIPS R-type funct codes and divider state encoding for the
// execute-stage arithmetic / HI-LO slice.
package ex_arith_hilo_pkg;

  localparam int DATA_BUS        = 32;
  localparam int DOUBLE_DATA_BUS = 64;
  localparam int FUNCT_BUS       = 6;

  localparam logic [FUNCT_BUS-1:0] FUNCT_ADD   = 6'h20;
  localparam logic [FUNCT_BUS-1:0] FUNCT_ADDU  = 6'h21;
  localparam logic [FUNCT_BUS-1:0] FUNCT_SUB   = 6'h22;
  localparam logic [FUNCT_BUS-1:0] FUNCT_SUBU  = 6'h23;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_BUS-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_BUS-1:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  function automatic logic is_div(input logic [FUNCT_BUS-1:0] f);
    return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

  function automatic logic is_mult(input logic [FUNCT_BUS-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
  endfunction

endpackage

// File: rtl/ex_arith_hilo_if.sv
// ID/EX-side bundle of the arithmetic/HI-LO slice: decode selects, operands,
// multiplier result, HI/LO read values in; results and HI/LO write request out.
interface ex_arith_hilo_if;
  import ex_arith_hilo_pkg::*;

  logic [FUNCT_BUS-1:0]       funct;
  logic                       add_en;
  logic                       div_en;
  logic                       hilo_en;
  logic [DATA_BUS-1:0]        operand_1;
  logic [DATA_BUS-1:0]        operand_2;
  logic [DOUBLE_DATA_BUS-1:0] mult_result;
  logic                       mult_done;
  logic [DATA_BUS-1:0]        hi_read_data;
  logic [DATA_BUS-1:0]        lo_read_data;

  logic [DATA_BUS-1:0]        adder_result;
  logic                       overflow_flag;
  logic [DOUBLE_DATA_BUS-1:0] div_result;
  logic                       div_done;
  logic                       stall_request;
  logic [DATA_BUS-1:0]        hilo_result;
  logic [DATA_BUS-1:0]        hi_write_data;
  logic [DATA_BUS-1:0]        lo_write_data;
  logic                       hilo_write_en;

  modport master (
    output funct, add_en, div_en, hilo_en, operand_1, operand_2,
           mult_result, mult_done, hi_read_data, lo_read_data,
    input  adder_result, overflow_flag, div_result, div_done, stall_request,
           hilo_result, hi_write_data, lo_write_data, hilo_write_en
  );

  modport slave (
    input  funct, add_en, div_en, hilo_en, operand_1, operand_2,
           mult_result, mult_done, hi_read_data, lo_read_data,
    output adder_result, overflow_flag, div_result, div_done, stall_request,
           hilo_result, hi_write_data, lo_write_data, hilo_write_en
  );

endinterface

// File: rtl/ex_arith_hilo_adder.sv
// Combinational 32-bit add/subtract with trapping-op signed overflow detection.
module ex_arith_hilo_adder
  import ex_arith_hilo_pkg::*;
#(
  parameter int DATA_W = DATA_BUS
) (
  input  logic [FUNCT_BUS-1:0]     funct,
  input  logic                     add_en,
  input  logic signed [DATA_W-1:0] operand_1,
  input  logic signed [DATA_W-1:0] operand_2,
  output logic [DATA_W-1:0]        adder_result,
  output logic                     overflow_flag
);

  logic signed [DATA_W-1:0] addend;
  logic signed [DATA_W-1:0] sum;
  logic                     is_add;
  logic                     is_sub;
  logic                     trap_op;

  always_comb begin
    is_add  = (funct == FUNCT_ADD) || (funct == FUNCT_ADDU);
    is_sub  = (funct == FUNCT_SUB) || (funct == FUNCT_SUBU);
    trap_op = (funct == FUNCT_ADD) || (funct == FUNCT_SUB);
    addend  = is_sub ? -operand_2 : operand_2;
    sum     = operand_1 + addend;

    adder_result  = '0;
    overflow_flag = 1'b0;
    if (add_en && (is_add || is_sub)) begin
      adder_result = sum;
      // Same-signed inputs producing an opposite-signed sum is the overflow case.
      overflow_flag = trap_op
                   && (operand_1[DATA_W-1] == addend[DATA_W-1])
                   && (sum[DATA_W-1] != operand_1[DATA_W-1]);
    end
  end

endmodule

// File: rtl/ex_arith_hilo_divider.sv
// Sequential restoring divider: capture, DATA_W shift/subtract iterations,
// then a one-cycle DONE with the sign-corrected {remainder, quotient}.
module ex_arith_hilo_divider
  import ex_arith_hilo_pkg::*;
#(
  parameter int DATA_W = DATA_BUS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FUNCT_BUS-1:0]  funct,
  input  logic                  div_en,
  input  logic [DATA_W-1:0]     operand_1,
  input  logic [DATA_W-1:0]     operand_2,
  output logic [2*DATA_W-1:0]   div_result,
  output logic                  div_done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return (~v) + DATA_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? negate(v) : v;
  endfunction

  div_state_t        state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic              neg_quo;
  logic              neg_rem;
  logic              start;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quo_next;

  assign start = (state == DIV_IDLE) && div_en && is_div(funct);

  // A zero divisor never borrows, so the quotient fills with ones and the
  // remainder ends up holding the dividend magnitude.
  always_comb begin
    shifted = {rem, quo[DATA_W-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[DATA_W]) begin
      rem_next = trial[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_next = shifted[DATA_W-1:0];
      quo_next = {quo[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DIV_IDLE;
      count      <= '0;
      div_done   <= 1'b0;
      div_result <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            state <= DIV_BUSY;
            count <= '0;
          end
        end
        DIV_BUSY: begin
          count <= count + CNT_W'(1);
          if (count == LAST_ITER) begin
            state      <= DIV_DONE;
            div_done   <= 1'b1;
            div_result <= {neg_rem ? negate(rem_next) : rem_next,
                           neg_quo ? negate(quo_next) : quo_next};
          end
        end
        DIV_DONE: begin
          state    <= DIV_IDLE;
          div_done <= 1'b0;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  // Working registers carry no reset: they are always reloaded at capture.
  always_ff @(posedge clk) begin
    if (start) begin
      rem <= '0;
      if (funct == FUNCT_DIV) begin
        quo     <= magnitude(operand_1);
        divisor <= magnitude(operand_2);
        neg_quo <= operand_1[DATA_W-1] ^ operand_2[DATA_W-1];
        neg_rem <= operand_1[DATA_W-1];
      end else begin
        quo     <= operand_1;
        divisor <= operand_2;
        neg_quo <= 1'b0;
        neg_rem <= 1'b0;
      end
    end else if (state == DIV_BUSY) begin
      rem <= rem_next;
      quo <= quo_next;
    end
  end

endmodule

// File: rtl/ex_arith_hilo_hilo_gen.sv
// HI/LO access generator: MFHI/MFLO read mux and prioritised HI/LO write request.
module ex_arith_hilo_hilo_gen
  import ex_arith_hilo_pkg::*;
#(
  parameter int DATA_W = DATA_BUS
) (
  input  logic [FUNCT_BUS-1:0] funct,
  input  logic                 hilo_en,
  input  logic                 div_done,
  input  logic [2*DATA_W-1:0]  div_result,
  input  logic                 mult_done,
  input  logic [2*DATA_W-1:0]  mult_result,
  input  logic [DATA_W-1:0]    operand_1,
  input  logic [DATA_W-1:0]    hi_read_data,
  input  logic [DATA_W-1:0]    lo_read_data,
  output logic [DATA_W-1:0]    hilo_result,
  output logic [DATA_W-1:0]    hi_write_data,
  output logic [DATA_W-1:0]    lo_write_data,
  output logic                 hilo_write_en
);

  always_comb begin
    hilo_write_en = 1'b0;
    hi_write_data = hi_read_data;
    lo_write_data = lo_read_data;
    if (div_done && is_div(funct)) begin
      hilo_write_en = 1'b1;
      {hi_write_data, lo_write_data} = div_result;
    end else if (mult_done && is_mult(funct)) begin
      hilo_write_en = 1'b1;
      {hi_write_data, lo_write_data} = mult_result;
    end else if (hilo_en && (funct == FUNCT_MTHI)) begin
      hilo_write_en = 1'b1;
      hi_write_data = operand_1;
    end else if (hilo_en && (funct == FUNCT_MTLO)) begin
      hilo_write_en = 1'b1;
      lo_write_data = operand_1;
    end
  end

  always_comb begin
    hilo_result = '0;
    if (hilo_en && (funct == FUNCT_MFHI)) hilo_result = hi_read_data;
    else if (hilo_en && (funct == FUNCT_MFLO)) hilo_result = lo_read_data;
  end

endmodule

// File: rtl/ex_arith_hilo.sv
// Execute-stage arithmetic/HI-LO slice: adder, sequential divider and HI/LO
// access generator, plus the divide stall request.
module ex_arith_hilo
  import ex_arith_hilo_pkg::*;
(
  input logic           clk,
  input logic           rst,
  ex_arith_hilo_if.slave bus
);

  ex_arith_hilo_adder #(.DATA_W(DATA_BUS)) u_adder (
    .funct         (bus.funct),
    .add_en        (bus.add_en),
    .operand_1     (bus.operand_1),
    .operand_2     (bus.operand_2),
    .adder_result  (bus.adder_result),
    .overflow_flag (bus.overflow_flag)
  );

  ex_arith_hilo_divider #(.DATA_W(DATA_BUS)) u_divider (
    .clk        (clk),
    .rst        (rst),
    .funct      (bus.funct),
    .div_en     (bus.div_en),
    .operand_1  (bus.operand_1),
    .operand_2  (bus.operand_2),
    .div_result (bus.div_result),
    .div_done   (bus.div_done)
  );

  ex_arith_hilo_hilo_gen #(.DATA_W(DATA_BUS)) u_hilo_gen (
    .funct         (bus.funct),
    .hilo_en       (bus.hilo_en),
    .div_done      (bus.div_done),
    .div_result    (bus.div_result),
    .mult_done     (bus.mult_done),
    .mult_result   (bus.mult_result),
    .operand_1     (bus.operand_1),
    .hi_read_data  (bus.hi_read_data),
    .lo_read_data  (bus.lo_read_data),
    .hilo_result   (bus.hilo_result),
    .hi_write_data (bus.hi_write_data),
    .lo_write_data (bus.lo_write_data),
    .hilo_write_en (bus.hilo_write_en)
  );

  assign bus.stall_request = bus.div_en & ~bus.div_done;

endmodule

// File: tb/tb_ex_arith_hilo.sv
// Directed bench for ex_arith_hilo: adder, HI/LO generator and divider timing,
// with hand-computed expected values.
module tb_ex_arith_hilo;
  import ex_arith_hilo_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   stalls;
  logic seen;

  ex_arith_hilo_if bus ();

  ex_arith_hilo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until div_done, bounded; returns edges taken and stall-high samples.
  task automatic wait_done(input int start, output int cycles, output int stall_cnt);
    cycles    = start;
    stall_cnt = bus.stall_request ? 1 : 0;
    while (!bus.div_done && cycles < 100) begin
      step();
      cycles++;
      if (bus.stall_request) stall_cnt++;
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.funct        = FUNCT_ADD;
    bus.add_en       = 1'b1;
    bus.div_en       = 1'b0;
    bus.hilo_en      = 1'b0;
    bus.operand_1    = 32'd1;
    bus.operand_2    = 32'd2;
    bus.mult_result  = '0;
    bus.mult_done    = 1'b0;
    bus.hi_read_data = 32'h55;
    bus.lo_read_data = 32'hAA;
    repeat (3) step();

    check("rst_div_done", bus.div_done, 0);
    check("rst_div_result", bus.div_result, 0);
    check("rst_stall", bus.stall_request, 0);
    check("rst_adder_tracks", bus.adder_result, 32'd3);
    rst = 1'b0;
    step();

    bus.funct = FUNCT_ADD; bus.operand_1 = 32'h7FFFFFFF; bus.operand_2 = 32'h1; #1;
    check("add_result", bus.adder_result, 32'h80000000);
    check("add_ovf", bus.overflow_flag, 1);
    bus.funct = FUNCT_ADDU; #1;
    check("addu_result", bus.adder_result, 32'h80000000);
    check("addu_ovf", bus.overflow_flag, 0);
    bus.funct = FUNCT_SUB; bus.operand_1 = 32'd5; bus.operand_2 = 32'd7; #1;
    check("sub_result", bus.adder_result, 32'hFFFFFFFE);
    check("sub_ovf", bus.overflow_flag, 0);
    bus.operand_1 = 32'h80000000; bus.operand_2 = 32'h1; #1;
    check("sub_min_result", bus.adder_result, 32'h7FFFFFFF);
    check("sub_min_ovf", bus.overflow_flag, 1);
    bus.funct = FUNCT_SUBU; #1;
    check("subu_min_ovf", bus.overflow_flag, 0);
    bus.funct = FUNCT_ADD; bus.add_en = 1'b0; #1;
    check("add_dis_result", bus.adder_result, 0);
    check("add_dis_ovf", bus.overflow_flag, 0);

    bus.hilo_en = 1'b1; bus.funct = FUNCT_MTHI; bus.operand_1 = 32'h1234; #1;
    check("mthi_hi", bus.hi_write_data, 32'h1234);
    check("mthi_lo", bus.lo_write_data, 32'hAA);
    check("mthi_en", bus.hilo_write_en, 1);
    bus.funct = FUNCT_MTLO; #1;
    check("mtlo_hi", bus.hi_write_data, 32'h55);
    check("mtlo_lo", bus.lo_write_data, 32'h1234);
    check("mtlo_en", bus.hilo_write_en, 1);
    bus.funct = FUNCT_MFLO; #1;
    check("mflo", bus.hilo_result, 32'hAA);
    check("mflo_no_write", bus.hilo_write_en, 0);
    bus.funct = FUNCT_MFHI; #1;
    check("mfhi", bus.hilo_result, 32'h55);
    bus.hilo_en = 1'b0; #1;
    check("mfhi_dis", bus.hilo_result, 0);
    bus.funct = FUNCT_MULT; bus.mult_done = 1'b1; bus.mult_result = 64'h1_00000002; #1;
    check("mult_hi", bus.hi_write_data, 32'h1);
    check("mult_lo", bus.lo_write_data, 32'h2);
    check("mult_en", bus.hilo_write_en, 1);
    bus.funct = FUNCT_ADDU; #1;
    check("mult_wrong_funct_en", bus.hilo_write_en, 0);
    check("idle_hi_passthru", bus.hi_write_data, 32'h55);
    bus.mult_done = 1'b0;
    step();

    // DIV -7 / 2 held
    bus.funct = FUNCT_DIV; bus.div_en = 1'b1;
    bus.operand_1 = 32'hFFFFFFF9; bus.operand_2 = 32'd2; #1;
    wait_done(0, cyc, stalls);
    check("div1_latency", cyc, 33);
    check("div1_stall_cycles", stalls, 33);
    check("div1_result", bus.div_result, 64'hFFFFFFFF_FFFFFFFD);
    check("div1_stall_at_done", bus.stall_request, 0);
    check("div1_wen", bus.hilo_write_en, 1);
    check("div1_hi", bus.hi_write_data, 32'hFFFFFFFF);
    check("div1_lo", bus.lo_write_data, 32'hFFFFFFFD);
    bus.div_en = 1'b0;
    step();
    check("div1_done_pulse", bus.div_done, 0);
    check("div1_wen_pulse", bus.hilo_write_en, 0);
    check("div1_result_held", bus.div_result, 64'hFFFFFFFF_FFFFFFFD);

    // DIVU by zero; operands and div_en change after capture
    bus.funct = FUNCT_DIVU; bus.div_en = 1'b1;
    bus.operand_1 = 32'hFFFFFFFF; bus.operand_2 = 32'd0; #1;
    step();
    bus.operand_1 = 32'd3; bus.operand_2 = 32'd1; bus.div_en = 1'b0;
    wait_done(1, cyc, stalls);
    check("divu0_latency", cyc, 33);
    check("divu0_result", bus.div_result, 64'hFFFFFFFF_FFFFFFFF);
    check("divu0_wen", bus.hilo_write_en, 1);
    step();

    // Signed DIV by zero: -7 / 0
    bus.funct = FUNCT_DIV; bus.div_en = 1'b1;
    bus.operand_1 = 32'hFFFFFFF9; bus.operand_2 = 32'd0; #1;
    wait_done(0, cyc, stalls);
    check("div0_latency", cyc, 33);
    check("div0_result", bus.div_result, 64'hFFFFFFF9_00000001);
    bus.div_en = 1'b0;
    step();

    // Back-to-back: 100 / -7, then 0x80000000 / -1 with div_en held
    bus.funct = FUNCT_DIV; bus.div_en = 1'b1;
    bus.operand_1 = 32'd100; bus.operand_2 = 32'hFFFFFFF9; #1;
    wait_done(0, cyc, stalls);
    check("b2b_first_latency", cyc, 33);
    check("b2b_first_result", bus.div_result, 64'h00000002_FFFFFFF2);
    bus.operand_1 = 32'h80000000; bus.operand_2 = 32'hFFFFFFFF;
    step();
    check("b2b_gap_done", bus.div_done, 0);
    check("b2b_gap_stall", bus.stall_request, 1);
    wait_done(1, cyc, stalls);
    check("b2b_second_latency", cyc, 34);
    check("b2b_second_result", bus.div_result, 64'h00000000_80000000);
    check("b2b_second_lo", bus.lo_write_data, 32'h80000000);
    bus.div_en = 1'b0;
    step();

    // Reset during iteration 10, then a clean division
    bus.operand_1 = 32'd20; bus.operand_2 = 32'd3; bus.div_en = 1'b1; #1;
    repeat (11) step();
    check("mid_div_not_done", bus.div_done, 0);
    rst = 1'b1; bus.div_en = 1'b0;
    step();
    rst = 1'b0;
    check("rst_mid_result", bus.div_result, 0);
    seen = 1'b0;
    repeat (40) begin
      step();
      if (bus.div_done || bus.hilo_write_en) seen = 1'b1;
    end
    check("rst_mid_no_pulse", seen, 0);
    check("rst_mid_result_after", bus.div_result, 0);
    bus.div_en = 1'b1; #1;
    wait_done(0, cyc, stalls);
    check("post_rst_latency", cyc, 33);
    check("post_rst_result", bus.div_result, 64'h00000002_00000006);
    bus.div_en = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
